// File: rtl/imem_responder.sv
// Instruction-memory responder: word-addressed array behind a valid/ready fetch
// interface, returning in-order responses after a fixed latency.
module imem_responder #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int MAX_OUT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_error,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int AW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [CW-1:0]   FULL    = CW'(MAX_OUT);
  localparam logic [PW-1:0]   LAST    = PW'(MAX_OUT - 1);
  localparam logic [XLEN-3:0] WORDS   = (XLEN - 2)'(DEPTH);
  // An entry written at the acceptance edge is visible one cycle later, so the
  // stored age reaching LATENCY-1 marks the cycle LATENCY after acceptance.
  localparam logic [AW-1:0]   AGE_RDY = AW'(LATENCY - 1);

  logic [XLEN-1:0] mem [DEPTH];

  logic [XLEN-1:0] data_q [MAX_OUT];
  logic            err_q  [MAX_OUT];
  logic [AW-1:0]   age_q  [MAX_OUT];

  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;

  logic          reqFault;
  logic          wrOk;
  logic [IW-1:0] reqIdx;
  logic [IW-1:0] wrIdx;
  logic          headReady;
  logic          accept;
  logic          retire;

  assign reqFault = (req_addr[1:0] != 2'b00) || (req_addr[XLEN-1:2] >= WORDS);
  assign reqIdx   = req_addr[IW+1:2];
  assign wrOk     = wr_en && (wr_addr[1:0] == 2'b00) && (wr_addr[XLEN-1:2] < WORDS);
  assign wrIdx    = wr_addr[IW+1:2];

  assign req_ready = !rst && (count_q < FULL);
  assign headReady = (count_q != '0) && (age_q[rdPtr_q] == AGE_RDY);
  assign rsp_valid = !rst && headReady;
  assign rsp_data  = rsp_valid ? data_q[rdPtr_q] : '0;
  assign rsp_error = rsp_valid ? err_q[rdPtr_q] : 1'b0;

  assign accept = req_valid && req_ready;
  assign retire = rsp_valid && rsp_ready;

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (accept) begin
      wrPtr_d = (wrPtr_q == LAST) ? '0 : wrPtr_q + 1'b1;
    end
    if (retire) begin
      rdPtr_d = (rdPtr_q == LAST) ? '0 : rdPtr_q + 1'b1;
    end
    case ({accept, retire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Entry payload is captured from the array before this edge's preload write lands.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUT; i++) begin
      if (accept && (wrPtr_q == PW'(i))) begin
        age_q[i]  <= '0;
        data_q[i] <= reqFault ? '0 : mem[reqIdx];
        err_q[i]  <= reqFault;
      end else if (age_q[i] != AGE_RDY) begin
        age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wrOk) begin
      mem[wrIdx] <= wr_data;
    end
  end

endmodule
